gearbox_rx: RTL and testbench

GEARBOX_RX -- requirements
Module: gearbox_rx

---
 rtl/pcs_pkg.sv | 11 +
 rtl/gearbox_rx_shift.sv | 50 +++++
 rtl/gearbox_rx.sv | 78 +++++++
 tb/tb_gearbox_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS block-format constants for the 64b/66b gearboxes.
package pcs_pkg;

  localparam int unsigned HEAD_W       = 2;
  localparam int unsigned BLOCK_DATA_W = 64;
  localparam int unsigned BLOCK_W      = HEAD_W + BLOCK_DATA_W;

  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/gearbox_rx_shift.sv
// Combinational extract stage: merges the new word above the buffered bits,
// applies an optional one-bit slip and peels off one block when enough bits exist.
module gearbox_rx_shift
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BLK_W  = BLOCK_W,
  localparam int unsigned BUF_W = 2 * BLK_W - 2,
  localparam int unsigned CNT_W = $clog2(BLK_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [BUF_W-1:0]  buf_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              slip_i,
  output logic              form_c,
  output logic [BLK_W-1:0]  block_c,
  output logic [BUF_W-1:0]  rem_c,
  output logic [CNT_W-1:0]  cnt_next_c
);

  localparam int unsigned AVAIL_W = $clog2(BUF_W);

  logic [BUF_W-1:0]   mask;
  logic [BUF_W-1:0]   stream_raw;
  logic [BUF_W-1:0]   stream;
  logic [AVAIL_W-1:0] avail_raw;
  logic [AVAIL_W-1:0] avail;

  // Bits above cnt in the buffer are stale and must not leak into the stream.
  always_comb begin
    mask       = (BUF_W'(1) << cnt_i) - BUF_W'(1);
    stream_raw = (BUF_W'(data_i) << cnt_i) | (buf_i & mask);
    avail_raw  = AVAIL_W'(cnt_i) + AVAIL_W'(DATA_W);
    stream     = stream_raw;
    avail      = avail_raw;
    if (slip_i) begin
      stream = stream_raw >> 1;
      avail  = avail_raw - AVAIL_W'(1);
    end
    form_c     = (avail >= AVAIL_W'(BLK_W));
    block_c    = stream[BLK_W-1:0];
    rem_c      = stream;
    cnt_next_c = CNT_W'(avail);
    if (form_c) begin
      rem_c      = stream >> BLK_W;
      cnt_next_c = CNT_W'(avail - AVAIL_W'(BLK_W));
    end
  end

endmodule

// File: rtl/gearbox_rx.sv
// 64b/66b receive gearbox: PMA words in, registered 66-bit blocks out.
// Holds the bit buffer, fill count and output registers around gearbox_rx_shift.
module gearbox_rx #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned HEAD_W       = pcs_pkg::HEAD_W,
  parameter int unsigned BLOCK_DATA_W = pcs_pkg::BLOCK_DATA_W,
  localparam int unsigned BLK_W = HEAD_W + BLOCK_DATA_W,
  localparam int unsigned BUF_W = 2 * BLK_W - 2,
  localparam int unsigned CNT_W = $clog2(BLK_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    slip_i,
  output logic                    valid_o,
  output logic [HEAD_W-1:0]       head_o,
  output logic [BLOCK_DATA_W-1:0] data_o
);

  logic [BUF_W-1:0]        buf_q,   buf_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    valid_q, valid_d;
  logic [HEAD_W-1:0]       head_q,  head_d;
  logic [BLOCK_DATA_W-1:0] data_q,  data_d;

  logic                    form_c;
  logic [BLK_W-1:0]        block_c;
  logic [BUF_W-1:0]        rem_c;
  logic [CNT_W-1:0]        cnt_next_c;

  gearbox_rx_shift #(
    .DATA_W (DATA_W),
    .BLK_W  (BLK_W)
  ) u_shift (
    .data_i     (data_i),
    .buf_i      (buf_q),
    .cnt_i      (cnt_q),
    .slip_i     (slip_i),
    .form_c     (form_c),
    .block_c    (block_c),
    .rem_c      (rem_c),
    .cnt_next_c (cnt_next_c)
  );

  // Output payload only updates when a block is formed; otherwise it holds.
  always_comb begin
    buf_d   = rem_c;
    cnt_d   = cnt_next_c;
    valid_d = form_c;
    head_d  = head_q;
    data_d  = data_q;
    if (form_c) begin
      head_d = block_c[HEAD_W-1:0];
      data_d = block_c[BLK_W-1:HEAD_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_gearbox_rx.sv
// Directed bench for gearbox_rx: a serial tx source feeds the receiver and a
// bit-queue reference predicts every output block and the fill count.
module tb_gearbox_rx;
  import pcs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_i;
  logic        slip_i;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic        txq[$];
  logic        rq[$];
  logic [63:0] seq = '0;
  logic [1:0]  last_head;
  logic [63:0] last_data;

  always #5 clk = ~clk;

  gearbox_rx dut (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_i),
    .slip_i  (slip_i),
    .valid_o (valid_o),
    .head_o  (head_o),
    .data_o  (data_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_blk(input logic [65:0] b);
    for (int i = 0; i < 66; i++) txq.push_back(b[i]);
  endtask

  // One clock: send a word (optionally slipping), then check the registered result.
  task automatic cycle(input logic s);
    logic [63:0] w;
    logic [65:0] eb;
    logic        ev;
    while (txq.size() < 64) begin
      push_blk({seq, SYNC_DATA});
      seq++;
    end
    for (int i = 0; i < 64; i++) w[i] = txq.pop_front();
    data_i = w;
    slip_i = s;
    for (int i = 0; i < 64; i++) rq.push_back(w[i]);
    if (s) void'(rq.pop_front());
    ev = 1'b0;
    eb = '0;
    if (rq.size() >= 66) begin
      ev = 1'b1;
      for (int i = 0; i < 66; i++) eb[i] = rq.pop_front();
    end
    @(posedge clk);
    #1;
    slip_i = 1'b0;
    chk("valid", 128'(valid_o), 128'(ev));
    if (ev) begin
      chk("head", 128'(head_o), 128'(eb[1:0]));
      chk("data", 128'(data_o), 128'(eb[65:2]));
      last_head = eb[1:0];
      last_data = eb[65:2];
    end else begin
      chk("head_hold", 128'(head_o), 128'(last_head));
      chk("data_hold", 128'(data_o), 128'(last_data));
    end
    chk("cnt", 128'(dut.cnt_q), 128'(rq.size()));
  endtask

  task automatic model_reset();
    rq.delete();
    txq.delete();
    last_head = '0;
    last_data = '0;
  endtask

  initial begin
    int          nv;
    int          n_mid;
    logic        found;
    logic        last_ev_ok;
    logic [63:0] s0;
    logic [63:0] d1;

    reset  = 1'b1;
    data_i = '0;
    slip_i = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_head", 128'(head_o), 128'(0));
    chk("rst_data", 128'(data_o), 128'(0));
    chk("rst_cnt", 128'(dut.cnt_q), 128'(0));

    // Known control block at bit 0: visible at cycle 2
    reset = 1'b0;
    push_blk({64'h0123456789ABCDEF, SYNC_CTRL});
    cycle(1'b0);
    chk("first_cnt64", 128'(dut.cnt_q), 128'(64));
    cycle(1'b0);
    chk("first_valid", 128'(valid_o), 128'(1));
    chk("first_head", 128'(head_o), 128'(2'b10));
    chk("first_data", 128'(data_o), 128'(64'h0123456789ABCDEF));

    // Loopback cadence: 96 blocks in 99 cycles
    nv = 0;
    for (int i = 0; i < 99; i++) begin
      cycle(1'b0);
      if (valid_o === 1'b1) nv++;
    end
    chk("loop_rate", 128'(nv), 128'(96));

    // 66 consecutive slips: realigned with exactly one block lost
    s0    = last_data;
    n_mid = 0;
    for (int k = 1; k <= 66; k++) begin
      cycle(1'b1);
      chk("slip_no_x", 128'($isunknown({valid_o, head_o, data_o})), 128'(0));
      if (k <= 65 && valid_o === 1'b1) n_mid++;
    end
    found = (valid_o === 1'b1);
    for (int i = 0; i < 3 && !found; i++) begin
      cycle(1'b0);
      found = (valid_o === 1'b1);
    end
    chk("slip66_found", 128'(found), 128'(1));
    d1 = data_o;
    chk("slip66_seq", 128'(d1), 128'(s0 + 64'(n_mid) + 64'd2));
    chk("slip66_head", 128'(head_o), 128'(SYNC_DATA));
    cycle(1'b0);
    if (valid_o !== 1'b1) cycle(1'b0);
    chk("slip66_next", 128'(data_o), 128'(d1 + 64'd1));

    // Mid-cycle reset while cnt=30 and a block is on the output
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0);
      found = (rq.size() == 30) && (valid_o === 1'b1);
    end
    chk("reach_cnt30_v", 128'(found), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 128'(valid_o), 128'(0));
    chk("async_head", 128'(head_o), 128'(0));
    chk("async_data", 128'(data_o), 128'(0));
    chk("async_cnt", 128'(dut.cnt_q), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    chk("post_rst_valid", 128'(valid_o), 128'(1));

    // Single slip at cnt=30 keeps 32 blocks per 33 cycles
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0);
      found = (rq.size() == 30);
    end
    chk("reach_cnt30", 128'(found), 128'(1));
    cycle(1'b1);
    nv = 0;
    for (int i = 0; i < 33; i++) begin
      cycle(1'b0);
      if (valid_o === 1'b1) nv++;
    end
    chk("slip1_rate", 128'(nv), 128'(32));

    // Slip when cnt=2: avail drops to 65, no block, cnt=65
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0);
      found = (rq.size() == 2);
    end
    chk("reach_cnt2", 128'(found), 128'(1));
    cycle(1'b1);
    chk("cnt2_slip_valid", 128'(valid_o), 128'(0));
    chk("cnt2_slip_cnt", 128'(dut.cnt_q), 128'(65));
    cycle(1'b0);
    last_ev_ok = (valid_o === 1'b1);
    chk("cnt65_next_valid", 128'(last_ev_ok), 128'(1));
    chk("cnt65_next_cnt", 128'(dut.cnt_q), 128'(63));
    repeat (4) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
